mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single physical memory port between the instruction-fetch requester (IF) and the load/store requester (LS) of the ysyx_220053 core.
- Accepts one request at a time from either side, holds it on the memory port until the memory accepts it, and routes the single response back to the owner.
- Sits between the IFU/LSU and the memory model or bus bridge. Exactly one transaction is in flight at a time.

Parameters:
- ADDR_W, 64, address width of all request ports.
- DATA_W, 64, data width of all read/write data ports.
- MASK_W, DATA_W/8, byte write-mask width.

Ports:
- clk  in  1  core clock.
- rst  in  1  reset, asynchronous, active-high.
- if_req_valid  in  1  IF read request.
- if_req_ready  out  1  IF request accepted this cycle.
- if_req_addr  in  ADDR_W  IF read address.
- if_rsp_valid  out  1  IF read data valid, one-cycle pulse.
- if_rsp_rdata  out  DATA_W  IF read data.
- ls_req_valid  in  1  LS request.
- ls_req_ready  out  1  LS request accepted this cycle.
- ls_req_addr  in  ADDR_W  LS address.
- ls_req_wen  in  1  1 = write, 0 = read.
- ls_req_wdata  in  DATA_W  LS write data.
- ls_req_wmask  in  MASK_W  LS byte enables.
- ls_rsp_valid  out  1  LS response, one-cycle pulse; for a write it is the completion.
- ls_rsp_rdata  out  DATA_W  LS read data.
- mem_req_valid  out  1  memory request.
- mem_req_ready  in  1  memory accepts request.
- mem_req_addr  out  ADDR_W  latched address.
- mem_req_wen  out  1  latched write enable.
- mem_req_wdata  out  DATA_W  latched write data.
- mem_req_wmask  out  MASK_W  latched mask.
- mem_rsp_valid  in  1  memory response.
- mem_rsp_rdata  in  DATA_W  memory read data.
- err_o  out  1  sticky protocol error.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE, owner to IF, last_grant to IF.
  - All latched request registers go to 0; err_o goes to 0.
  - All ready and valid outputs are 0 while rst is high.
- IDLE:
  - *_req_ready is combinational and goes to the granted requester only.
  - If exactly one side is valid, that side is granted.
  - If both are valid, the side NOT in last_grant wins. After reset this means LS wins the first tie.
  - On handshake (valid & ready): latch addr, wen, wdata and wmask, set owner and last_grant, and go to REQ.
  - For an IF grant, the latched wen=0 and wmask=0.
- REQ:
  - mem_req_valid=1 and mem_req_* driven from the latched registers, stable until accepted.
  - When mem_req_ready=1, go to RESP.
  - Both req_ready outputs are 0.
- RESP:
  - Wait for mem_rsp_valid.
  - In that cycle, owner's rsp_valid = 1 combinationally and owner's rsp_rdata = mem_rsp_rdata; go to IDLE.
  - Non-owner rsp_valid stays 0. There is no backpressure on responses.
- Latency:
  - Accept at cycle T, mem_req_valid at T+1.
  - Earliest requester response at T+2 (mem_req_ready at T+1, mem_rsp_valid at T+2).
  - Next accept no earlier than T+3.
- Outside RESP:
  - rsp_rdata outputs are don't-care; drive 0.
  - mem_rsp_valid outside RESP is ignored (no response routed) and sets err_o.
  - err_o clears only on reset.
- Reset mid-transaction drops the transaction. A response arriving after reset is handled as the stray case above.
- Requester valid deasserted while waiting (not yet granted) is legal; there is no state change.
- Addresses are passed unmodified. The block does no alignment or decode.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum: IDLE, REQ, RESP (2-bit);
  - owner enum: OWN_IF, OWN_LS;
  - default width constants.
- Sub-module rr_arb2: 2-way round-robin picker. Inputs are the two valid bits and last_grant; outputs are a one-hot grant. It is purely combinational.
- The top holds the FSM, the latches and the response routing.

Test Plan:
- IF only, addr 0x80000000; mem_req_ready=1 at T+1; mem_rsp_valid with rdata 0x00000013_00100093 at T+2 -> if_rsp_valid pulse at T+2 with that data; ls_rsp_valid stays 0.
- Both valid at T after reset, LS write addr 0x80001000, wdata 0x0123456789ABCDEF, wmask 0xFF:
  - -> LS granted first; mem_req_wen=1 with the latched values.
  - -> IF granted on the next IDLE; after that, with both valid again, LS wins.
- mem_req_ready held 0 for 5 cycles -> mem_req_* stable, no readies asserted; the transaction completes normally after ready.
- mem_rsp_valid pulsed in IDLE -> no rsp_valid on either side; err_o=1 and stays 1 until rst.
- rst asserted asynchronously during RESP -> outputs 0 immediately, state IDLE; a later response is ignored and sets err_o; the next IF request completes normally.
- Back-to-back IF requests with always-ready memory -> one if_rsp_valid every 3 cycles.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and width defaults for the two-requester memory-port arbiter.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 64;
  localparam int DATA_W_DEF = 64;
  localparam int MASK_W_DEF = DATA_W_DEF / 8;

  // Transaction phase of the single shared memory port
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  // Which requester owns the transaction in flight
  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_t;

  // One-hot grant encodings produced by the picker
  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_IF   = 2'b01;
  localparam logic [1:0] GNT_LS   = 2'b10;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin picker: a lone requester always wins; on a tie the
// side that was not granted last time wins. Purely combinational.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic       i_if_valid,
  input  logic       i_ls_valid,
  input  logic       i_last_ls,
  output logic [1:0] o_grant
);

  // Select the one-hot winner from the two valid bits and the last grant
  always_comb begin
    o_grant = GNT_NONE;
    if (i_if_valid && i_ls_valid) begin
      if (i_last_ls) begin
        o_grant = GNT_IF;
      end else begin
        o_grant = GNT_LS;
      end
    end else if (i_if_valid) begin
      o_grant = GNT_IF;
    end else if (i_ls_valid) begin
      o_grant = GNT_LS;
    end else begin
      o_grant = GNT_NONE;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch (IF) and load/store (LS).
// One transaction at a time: accept in IDLE, present to memory in REQ,
// route the single response back to the owner in RESP.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int MASK_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_rsp_valid,
  output logic [DATA_W-1:0] if_rsp_rdata,
  input  logic              ls_req_valid,
  output logic              ls_req_ready,
  input  logic [ADDR_W-1:0] ls_req_addr,
  input  logic              ls_req_wen,
  input  logic [DATA_W-1:0] ls_req_wdata,
  input  logic [MASK_W-1:0] ls_req_wmask,
  output logic              ls_rsp_valid,
  output logic [DATA_W-1:0] ls_rsp_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_req_wen,
  output logic [DATA_W-1:0] mem_req_wdata,
  output logic [MASK_W-1:0] mem_req_wmask,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_rdata,
  output logic              err_o
);

  state_t            r_state;
  state_t            w_state_nxt;
  owner_t            r_owner;
  owner_t            r_last_grant;
  logic [ADDR_W-1:0] r_addr;
  logic              r_wen;
  logic [DATA_W-1:0] r_wdata;
  logic [MASK_W-1:0] r_wmask;
  logic              r_err;
  logic [1:0]        w_grant;
  logic              w_last_ls;
  logic              w_hs_if;
  logic              w_hs_ls;

  assign w_last_ls = (r_last_grant == OWN_LS);

  rr_arb2 u_rr_arb2 (
    .i_if_valid (if_req_valid),
    .i_ls_valid (ls_req_valid),
    .i_last_ls  (w_last_ls),
    .o_grant    (w_grant)
  );

  // A grant in IDLE is a handshake: the ready goes only to the granted side
  assign w_hs_if = (r_state == IDLE) && w_grant[0];
  assign w_hs_ls = (r_state == IDLE) && w_grant[1];

  // The memory request always reflects the latched copy so it is stable
  assign mem_req_addr  = r_addr;
  assign mem_req_wen   = r_wen;
  assign mem_req_wdata = r_wdata;
  assign mem_req_wmask = r_wmask;
  assign err_o         = r_err;

  // Next-state decode plus readies, memory valid and response routing
  always_comb begin
    w_state_nxt   = r_state;
    if_req_ready  = 1'b0;
    ls_req_ready  = 1'b0;
    mem_req_valid = 1'b0;
    if_rsp_valid  = 1'b0;
    ls_rsp_valid  = 1'b0;
    if_rsp_rdata  = '0;
    ls_rsp_rdata  = '0;
    case (r_state)
      IDLE: begin
        // Readies are gated by reset so nothing handshakes while rst is high
        if (rst) begin
          if_req_ready = 1'b0;
          ls_req_ready = 1'b0;
        end else begin
          if_req_ready = w_grant[0];
          ls_req_ready = w_grant[1];
        end
        if (w_grant != GNT_NONE) begin
          w_state_nxt = REQ;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          w_state_nxt = RESP;
        end else begin
          w_state_nxt = REQ;
        end
      end
      RESP: begin
        if (r_owner == OWN_IF) begin
          if_rsp_rdata = mem_rsp_rdata;
          if_rsp_valid = mem_rsp_valid;
        end else begin
          ls_rsp_rdata = mem_rsp_rdata;
          ls_rsp_valid = mem_rsp_valid;
        end
        if (mem_rsp_valid) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = RESP;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Transaction phase register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Capture the granted request and remember who owns it and who went last
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr       <= '0;
      r_wen        <= 1'b0;
      r_wdata      <= '0;
      r_wmask      <= '0;
      r_owner      <= OWN_IF;
      r_last_grant <= OWN_IF;
    end else if (w_hs_ls) begin
      r_addr       <= ls_req_addr;
      r_wen        <= ls_req_wen;
      r_wdata      <= ls_req_wdata;
      r_wmask      <= ls_req_wmask;
      r_owner      <= OWN_LS;
      r_last_grant <= OWN_LS;
    end else if (w_hs_if) begin
      // Fetches are always reads with no byte enables
      r_addr       <= if_req_addr;
      r_wen        <= 1'b0;
      r_wdata      <= '0;
      r_wmask      <= '0;
      r_owner      <= OWN_IF;
      r_last_grant <= OWN_IF;
    end
  end

  // Sticky error: a memory response when no response is expected
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (mem_rsp_valid && (r_state != RESP)) begin
      r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random
// transactions, all checked against a transaction-level arbitration model.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req_valid;
  logic        if_req_ready;
  logic [63:0] if_req_addr;
  logic        if_rsp_valid;
  logic [63:0] if_rsp_rdata;
  logic        ls_req_valid;
  logic        ls_req_ready;
  logic [63:0] ls_req_addr;
  logic        ls_req_wen;
  logic [63:0] ls_req_wdata;
  logic [7:0]  ls_req_wmask;
  logic        ls_rsp_valid;
  logic [63:0] ls_rsp_rdata;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_req_addr;
  logic        mem_req_wen;
  logic [63:0] mem_req_wdata;
  logic [7:0]  mem_req_wmask;
  logic        mem_rsp_valid;
  logic [63:0] mem_rsp_rdata;
  logic        err_o;

  int checks = 0;
  int errors = 0;

  // Reference model state: who was granted last (1 = LS) and expected error
  bit last_ls;
  bit exp_err;

  mem_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .if_req_valid  (if_req_valid),
    .if_req_ready  (if_req_ready),
    .if_req_addr   (if_req_addr),
    .if_rsp_valid  (if_rsp_valid),
    .if_rsp_rdata  (if_rsp_rdata),
    .ls_req_valid  (ls_req_valid),
    .ls_req_ready  (ls_req_ready),
    .ls_req_addr   (ls_req_addr),
    .ls_req_wen    (ls_req_wen),
    .ls_req_wdata  (ls_req_wdata),
    .ls_req_wmask  (ls_req_wmask),
    .ls_rsp_valid  (ls_rsp_valid),
    .ls_rsp_rdata  (ls_rsp_rdata),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_req_wen   (mem_req_wen),
    .mem_req_wdata (mem_req_wdata),
    .mem_req_wmask (mem_req_wmask),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_rdata (mem_rsp_rdata),
    .err_o         (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rnd64();
    return {32'($urandom), 32'($urandom)};
  endfunction

  // One complete transaction, called with the DUT idle, 1 time unit after an edge
  task automatic do_txn(input string tag, input bit v_if, input bit v_ls,
                        input logic [63:0] a_if, input logic [63:0] a_ls,
                        input bit wen, input logic [63:0] wdata, input logic [7:0] wmask,
                        input int rdy_wait, input int rsp_wait, input logic [63:0] rdata);
    bit          win_ls;
    logic [63:0] e_addr;
    bit          e_wen;
    logic [7:0]  e_mask;
    // A lone requester wins; on a tie the one not served last time wins
    win_ls = v_ls && (!v_if || !last_ls);
    e_addr = win_ls ? a_ls : a_if;
    e_wen  = win_ls ? wen : 1'b0;
    e_mask = win_ls ? wmask : 8'h00;

    if_req_valid = v_if;  if_req_addr  = a_if;
    ls_req_valid = v_ls;  ls_req_addr  = a_ls;
    ls_req_wen   = wen;   ls_req_wdata = wdata; ls_req_wmask = wmask;
    #1;
    chk({tag, ":if_ready"}, 64'(if_req_ready), 64'(v_if && !win_ls));
    chk({tag, ":ls_ready"}, 64'(ls_req_ready), 64'(win_ls));
    chk({tag, ":idle_mvalid"}, 64'(mem_req_valid), 64'd0);
    tick();
    last_ls = win_ls;
    // Withdraw and scramble inputs to prove the request was latched
    if_req_valid = 1'b0; ls_req_valid = 1'b0;
    if_req_addr = rnd64(); ls_req_addr = rnd64(); ls_req_wdata = rnd64();
    ls_req_wmask = 8'($urandom); ls_req_wen = 1'($urandom);

    for (int k = 0; k <= rdy_wait; k++) begin
      mem_req_ready = (k == rdy_wait);
      #1;
      chk({tag, ":mvalid"}, 64'(mem_req_valid), 64'd1);
      chk({tag, ":maddr"}, mem_req_addr, e_addr);
      chk({tag, ":mwen"}, 64'(mem_req_wen), 64'(e_wen));
      chk({tag, ":mmask"}, 64'(mem_req_wmask), 64'(e_mask));
      if (win_ls) chk({tag, ":mwdata"}, mem_req_wdata, wdata);
      chk({tag, ":req_readies"}, 64'({if_req_ready, ls_req_ready}), 64'd0);
      tick();
    end
    mem_req_ready = 1'b0;

    for (int k = 0; k <= rsp_wait; k++) begin
      mem_rsp_valid = (k == rsp_wait);
      mem_rsp_rdata = (k == rsp_wait) ? rdata : rnd64();
      #1;
      chk({tag, ":if_rsp_valid"}, 64'(if_rsp_valid), 64'((k == rsp_wait) && !win_ls));
      chk({tag, ":ls_rsp_valid"}, 64'(ls_rsp_valid), 64'((k == rsp_wait) && win_ls));
      if (k == rsp_wait) chk({tag, ":rsp_rdata"}, win_ls ? ls_rsp_rdata : if_rsp_rdata, rdata);
      chk({tag, ":resp_mvalid"}, 64'(mem_req_valid), 64'd0);
      tick();
    end
    mem_rsp_valid = 1'b0;
    mem_rsp_rdata = 64'd0;
    #1;
    chk({tag, ":idle_rdata"}, if_rsp_rdata | ls_rsp_rdata, 64'd0);
    chk({tag, ":err"}, 64'(err_o), 64'(exp_err));
  endtask

  initial begin
    bit          pend;
    bit          pend_nxt;
    int          last_c;
    int          npulse;
    logic [1:0]  sel;

    // Reset with both requesters asserting: nothing may be acknowledged
    rst = 1'b1;
    if_req_valid = 1'b1; if_req_addr = 64'h0; ls_req_valid = 1'b1; ls_req_addr = 64'h0;
    ls_req_wen = 1'b0; ls_req_wdata = 64'h0; ls_req_wmask = 8'h00;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = 64'h0;
    last_ls = 1'b0; exp_err = 1'b0;
    #3;
    chk("rst:readies", 64'({if_req_ready, ls_req_ready}), 64'd0);
    chk("rst:mvalid", 64'(mem_req_valid), 64'd0);
    chk("rst:maddr", mem_req_addr, 64'd0);
    chk("rst:err", 64'(err_o), 64'd0);
    chk("rst:rsp", 64'({if_rsp_valid, ls_rsp_valid}), 64'd0);
    tick(); tick();
    if_req_valid = 1'b0; ls_req_valid = 1'b0;
    rst = 1'b0;
    tick();

    // IF-only fetch with the fastest memory
    do_txn("if_only", 1'b1, 1'b0, 64'h8000_0000, 64'h0, 1'b0, 64'h0, 8'h00,
           0, 0, 64'h0000_0013_0010_0093);

    // Ties: LS first after reset, then IF, then LS again
    do_txn("tie1", 1'b1, 1'b1, 64'h8000_0004, 64'h8000_1000, 1'b1,
           64'h0123_4567_89AB_CDEF, 8'hFF, 0, 0, 64'h0);
    do_txn("tie2", 1'b1, 1'b1, 64'h8000_0008, 64'h8000_1008, 1'b0,
           64'h0, 8'h0F, 0, 1, 64'hDEAD_BEEF_0000_0001);
    do_txn("tie3", 1'b1, 1'b1, 64'h8000_000C, 64'h8000_1010, 1'b1,
           64'hA5A5_5A5A_F00D_CAFE, 8'h3C, 1, 0, 64'h1111_2222_3333_4444);

    // Memory stalls for five cycles before accepting
    do_txn("stall", 1'b0, 1'b1, 64'h0, 64'h8000_2000, 1'b1,
           64'hFEED_FACE_CAFE_BEEF, 8'hF0, 5, 2, 64'h5555_AAAA_5555_AAAA);

    // Stray response in IDLE: nothing routed, error becomes sticky
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 64'h7777_7777_7777_7777;
    #1;
    chk("stray:rsp", 64'({if_rsp_valid, ls_rsp_valid}), 64'd0);
    chk("stray:err_before", 64'(err_o), 64'd0);
    tick();
    mem_rsp_valid = 1'b0;
    exp_err = 1'b1;
    #1;
    chk("stray:err_set", 64'(err_o), 64'd1);
    tick(); tick();
    chk("stray:err_sticky", 64'(err_o), 64'd1);

    // Reset in the middle of RESP drops the transaction at once
    if_req_valid = 1'b1; if_req_addr = 64'h8000_3000;
    tick();
    if_req_valid = 1'b0; mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    #2;
    rst = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_rdata = 64'h9999_0000_9999_0000;
    if_req_valid = 1'b1;
    #1;
    chk("arst:if_rsp", 64'(if_rsp_valid), 64'd0);
    chk("arst:mvalid", 64'(mem_req_valid), 64'd0);
    chk("arst:ready", 64'(if_req_ready), 64'd0);
    chk("arst:err", 64'(err_o), 64'd0);
    chk("arst:maddr", mem_req_addr, 64'd0);
    last_ls = 1'b0; exp_err = 1'b0;
    tick();
    rst = 1'b0; if_req_valid = 1'b0;
    // The late response now arrives while idle
    #1;
    chk("late:rsp", 64'({if_rsp_valid, ls_rsp_valid}), 64'd0);
    tick();
    mem_rsp_valid = 1'b0;
    exp_err = 1'b1;
    #1;
    chk("late:err", 64'(err_o), 64'd1);
    do_txn("after_rst", 1'b1, 1'b0, 64'h8000_3004, 64'h0, 1'b0, 64'h0, 8'h00,
           0, 0, 64'h0BAD_F00D_1234_5678);

    // Back-to-back fetches against an always-ready memory
    tick();
    pend = 1'b0; last_c = -1; npulse = 0;
    if_req_valid = 1'b1; if_req_addr = 64'h8000_4000; mem_req_ready = 1'b1;
    for (int c = 0; c < 15; c++) begin
      mem_rsp_valid = pend;
      mem_rsp_rdata = 64'(c);
      #1;
      pend_nxt = mem_req_valid;
      if (if_rsp_valid) begin
        if (last_c >= 0) chk("b2b:gap", 64'(c - last_c), 64'd3);
        chk("b2b:rdata", if_rsp_rdata, 64'(c));
        last_c = c;
        npulse++;
      end
      tick();
      pend = pend_nxt;
    end
    if_req_valid = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    chk("b2b:count", 64'(npulse), 64'd5);
    tick();
    // The fetches above leave IF as the last grant
    last_ls = 1'b0;

    // Randomized traffic
    for (int n = 0; n < 30; n++) begin
      sel = 2'($urandom_range(1, 3));
      do_txn($sformatf("rnd%0d", n), sel[0], sel[1], rnd64(), rnd64(), 1'($urandom),
             rnd64(), 8'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             rnd64());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
